// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer and downstream system reset generator
//
// Purpose: drives the PLL reset, waits for the (asynchronous) PLL locked flag
// with timeout and bounded retry, qualifies lock stability, then releases the
// downstream system reset. Runs entirely on the free-running reference clock.
//
// Ports:
//   refclk     in   reference clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   pll_locked in   PLL locked flag, asynchronous to refclk
//   restart    in   single-cycle request to restart the sequence
//   pll_rst    out  reset to the PLL, active-high
//   sys_rst    out  downstream system reset, active-high
//   lock_ok    out  high while in RUN
//   fail       out  high in FAIL
//   retry_cnt  out  retries performed in the current sequence
//   state_o    out  state encoding (debug)
//   loss_cnt   out  lock-loss events seen in RUN, saturating
//                   (present only when PLL_LOCK_LOSS_COUNT_EN is defined)
//
// Optional feature macro: PLL_LOCK_LOSS_COUNT_EN

module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_ok,
  output logic       fail,
  output logic [7:0] retry_cnt,
`ifdef PLL_LOCK_LOSS_COUNT_EN
  output logic [7:0] loss_cnt,
`endif
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             locked_s;

  // Output pattern {pll_rst, sys_rst, lock_ok, fail} for the state being
  // entered; loaded together with the state so outputs are registered.
  function automatic logic [3:0] outs_of(state_t s);
    case (s)
      S_RESET_PLL: outs_of = 4'b1100;
      S_WAIT_LOCK: outs_of = 4'b0100;
      S_STABILIZE: outs_of = 4'b0100;
      S_RUN:       outs_of = 4'b0010;
      S_FAIL:      outs_of = 4'b1101;
      default:     outs_of = 4'b1100;
    endcase
  endfunction

  assign state_o = state;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= 8'd0;
      sync1     <= 1'b0;
      locked_s  <= 1'b0;
      {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_RESET_PLL);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      loss_cnt  <= 8'd0;
`endif
    end else begin
      // Two-flop synchronizer; only locked_s is ever looked at.
      sync1    <= pll_locked;
      locked_s <= sync1;

      if (restart) begin
        state     <= S_RESET_PLL;
        cnt       <= '0;
        retry_cnt <= 8'd0;
        {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_RESET_PLL);
      end else begin
        case (state)
          S_RESET_PLL: begin
            if (cnt == RST_LAST) begin
              cnt   <= '0;
              state <= S_WAIT_LOCK;
              {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_WAIT_LOCK);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_WAIT_LOCK: begin
            if (locked_s) begin
              cnt   <= '0;
              state <= S_STABILIZE;
              {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_STABILIZE);
            end else if (cnt == TIMEOUT_LAST) begin
              cnt <= '0;
              if (retry_cnt == RETRY_MAX) begin
                state <= S_FAIL;
                {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_FAIL);
              end else begin
                retry_cnt <= retry_cnt + 8'd1;
                state     <= S_RESET_PLL;
                {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_RESET_PLL);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_STABILIZE: begin
            // Any low cycle restarts qualification and the lock timeout.
            if (!locked_s) begin
              cnt   <= '0;
              state <= S_WAIT_LOCK;
              {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_WAIT_LOCK);
            end else if (cnt == STABLE_LAST) begin
              cnt   <= '0;
              state <= S_RUN;
              {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_RUN);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_RUN: begin
            if (!locked_s) begin
              cnt       <= '0;
              retry_cnt <= 8'd0;
              state     <= S_RESET_PLL;
              {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_RESET_PLL);
`ifdef PLL_LOCK_LOSS_COUNT_EN
              if (loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
              end
`endif
            end
          end

          S_FAIL: begin
            cnt <= '0;
          end

          default: begin
            cnt       <= '0;
            retry_cnt <= 8'd0;
            state     <= S_RESET_PLL;
            {pll_rst, sys_rst, lock_ok, fail} <= outs_of(S_RESET_PLL);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer

module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_ok;
  logic       fail;
  logic [7:0] retry_cnt;
  logic [2:0] state_o;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (16)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .lock_ok   (lock_ok),
    .fail      (fail),
    .retry_cnt (retry_cnt),
`ifdef PLL_LOCK_LOSS_COUNT_EN
    .loss_cnt  (loss_cnt),
`endif
    .state_o   (state_o)
  );

  always #10 refclk = ~refclk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // One comparison of the full observable state.
  task automatic chk(input string tag, input logic [2:0] st, input logic pr,
                     input logic sr, input logic lo, input logic fa,
                     input logic [7:0] rc);
    logic [14:0] obs;
    logic [14:0] exp;
    obs = {state_o, pll_rst, sys_rst, lock_ok, fail, retry_cnt};
    exp = {st, pr, sr, lo, fa, rc};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed st=%0d prst=%b srst=%b lok=%b fail=%b rc=%0d, expected st=%0d prst=%b srst=%b lok=%b fail=%b rc=%0d",
             tag, obs[14:12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
             exp[14:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

`ifdef PLL_LOCK_LOSS_COUNT_EN
  task automatic chk_loss(input string tag, input logic [7:0] exp);
    vectors++;
    assert (loss_cnt === exp) else begin
      miscompares++;
      $error("FAIL %s: observed loss_cnt=%0d expected %0d", tag, loss_cnt, exp);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    pll_locked = 1'b1;
    restart = 1'b0;
    step(2);
    chk("reset_values", 3'd0, 1, 1, 0, 0, 8'd0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    chk_loss("reset_loss", 8'd0);
`endif

    // 1: lock held high from reset release
    rst = 1'b0;
    step(3);
    chk("s1_pll_rst_held", 3'd0, 1, 1, 0, 0, 8'd0);
    step(1);
    chk("s1_wait_lock", 3'd1, 0, 1, 0, 0, 8'd0);
    step(1);
    chk("s1_stabilize", 3'd2, 0, 1, 0, 0, 8'd0);
    step(7);
    chk("s1_stab_last", 3'd2, 0, 1, 0, 0, 8'd0);
    step(1);
    chk("s1_run", 3'd3, 0, 0, 1, 0, 8'd0);

    // 5: lock loss in RUN, response within 3 edges, relock
    pll_locked = 1'b0;
    step(2);
    chk("s5_sync_delay", 3'd3, 0, 0, 1, 0, 8'd0);
    step(1);
    chk("s5_sys_rst_3edges", 3'd0, 1, 1, 0, 0, 8'd0);
    pll_locked = 1'b1;
    step(3);
    chk("s5_pll_rst_pulse", 3'd0, 1, 1, 0, 0, 8'd0);
    step(1);
    chk("s5_wait", 3'd1, 0, 1, 0, 0, 8'd0);
    step(1);
    chk("s5_stab", 3'd2, 0, 1, 0, 0, 8'd0);
    step(8);
    chk("s5_run", 3'd3, 0, 0, 1, 0, 8'd0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    chk_loss("s5_loss_cnt", 8'd1);
`endif

    // 4: one-cycle lock drop at stabilize count 5
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("s4_restart", 3'd0, 1, 1, 0, 0, 8'd0);
    step(5);
    chk("s4_stab_enter", 3'd2, 0, 1, 0, 0, 8'd0);
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    chk("s4_stab_cnt5", 3'd2, 0, 1, 0, 0, 8'd0);
    step(1);
    chk("s4_back_to_wait", 3'd1, 0, 1, 0, 0, 8'd0);
    step(1);
    chk("s4_restab", 3'd2, 0, 1, 0, 0, 8'd0);
    step(7);
    chk("s4_still_stab", 3'd2, 0, 1, 0, 0, 8'd0);
    step(1);
    chk("s4_run", 3'd3, 0, 0, 1, 0, 8'd0);

    // 2: no lock ever, retries then FAIL
    pll_locked = 1'b0;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("s2_attempt1_rst", 3'd0, 1, 1, 0, 0, 8'd0);
    step(4);
    chk("s2_attempt1_wait", 3'd1, 0, 1, 0, 0, 8'd0);
    step(19);
    chk("s2_timeout_edge", 3'd1, 0, 1, 0, 0, 8'd0);
    step(1);
    chk("s2_retry1", 3'd0, 1, 1, 0, 0, 8'd1);
    step(24);
    chk("s2_retry2", 3'd0, 1, 1, 0, 0, 8'd2);
    step(24);
    chk("s2_fail", 3'd4, 1, 1, 0, 1, 8'd2);
    step(50);
    chk("s2_fail_hold", 3'd4, 1, 1, 0, 1, 8'd2);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    chk_loss("s2_loss_unchanged", 8'd1);
`endif

    // 3: restart out of FAIL with lock present
    restart = 1'b1;
    pll_locked = 1'b1;
    step(1);
    restart = 1'b0;
    chk("s3_restart", 3'd0, 1, 1, 0, 0, 8'd0);
    step(4);
    chk("s3_wait", 3'd1, 0, 1, 0, 0, 8'd0);
    step(9);
    chk("s3_run", 3'd3, 0, 0, 1, 0, 8'd0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    chk_loss("s3_restart_keeps_loss", 8'd1);
`endif

    // 6: rst together with restart mid-STABILIZE
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(5);
    chk("s6_stab", 3'd2, 0, 1, 0, 0, 8'd0);
    step(3);
    rst = 1'b1;
    restart = 1'b1;
    step(1);
    chk("s6_rst_wins", 3'd0, 1, 1, 0, 0, 8'd0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    chk_loss("s6_loss_cleared", 8'd0);
`endif
    rst = 1'b0;
    restart = 1'b0;
    step(4);
    chk("s6_wait_after_rst", 3'd1, 0, 1, 0, 0, 8'd0);
    step(1);
    chk("s6_stab_after_rst", 3'd2, 0, 1, 0, 0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
